// File: rtl/vga_pixel_capture.sv
// Pixel tap for the VGA output path: decimates visible pixels, tags start of
// frame, and buffers samples in a show-ahead FIFO with overflow accounting.
module vga_pixel_capture #(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned DECIM   = 4,
  parameter int unsigned DEPTH   = 16,
  parameter bit          VS_POL  = 1'b0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           visible,
  input  logic                           hsync,
  input  logic                           vsync,
  input  logic [COLOR_W-1:0]             red,
  input  logic [COLOR_W-1:0]             green,
  input  logic [COLOR_W-1:0]             blue,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [3*COLOR_W+2:0]           out_data,
  output logic [$clog2(DEPTH):0]         level,
  output logic                           overflow,
  input  logic                           clr_ovf,
  output logic [CNT_W-1:0]               drop_count
);

  localparam int unsigned DATA_W = 3 * COLOR_W + 3;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned DCW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DCW-1:0] DECIM_LAST = DCW'(DECIM - 1);
  localparam logic [PW-1:0]  FULL_LVL   = PW'(DEPTH);

  // Storage and pointers (one extra wrap bit distinguishes full from empty)
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     count_c, count_next_c;

  // Output-facing registers
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [PW-1:0]     level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  // Decimation and frame tagging
  logic [DCW-1:0]    decim_cnt_q, decim_cnt_d;
  logic              sof_pend_q, sof_pend_d;
  logic              vs_act_q;

  logic              vs_act_c;
  logic              vs_edge_c;
  logic              sample_c;
  logic              pop_c;
  logic              full_c;
  logic              push_c;
  logic              drop_c;
  logic [DATA_W-1:0] sample_data_c;

  // Sync edge detect and sample formation
  always_comb begin
    vs_act_c      = (vsync == VS_POL);
    vs_edge_c     = vs_act_c & ~vs_act_q;
    sample_c      = enable & visible & (decim_cnt_q == DECIM_LAST);
    sample_data_c = {sof_pend_q | vs_edge_c, hsync, vsync, red, green, blue};
  end

  // Decimation counter and pending start-of-frame next state
  always_comb begin
    decim_cnt_d = decim_cnt_q;
    sof_pend_d  = sof_pend_q;
    if (!enable) begin
      decim_cnt_d = '0;
    end else if (visible) begin
      decim_cnt_d = sample_c ? '0 : decim_cnt_q + DCW'(1);
    end
    // A sample taken on the edge cycle consumes the tag immediately
    if (sample_c) begin
      sof_pend_d = 1'b0;
    end else if (vs_edge_c) begin
      sof_pend_d = 1'b1;
    end
  end

  // FIFO control: push/pop arbitration, pointers and registered head
  always_comb begin
    count_c      = wr_ptr_q - rd_ptr_q;
    full_c       = (count_c == FULL_LVL);
    pop_c        = out_valid_q & out_ready;
    push_c       = sample_c & (~full_c | pop_c);
    drop_c       = sample_c & full_c & ~pop_c;
    wr_ptr_d     = wr_ptr_q + PW'(push_c);
    rd_ptr_d     = rd_ptr_q + PW'(pop_c);
    count_next_c = wr_ptr_d - rd_ptr_d;
    level_d      = count_next_c;
    out_valid_d  = (count_next_c != '0);
    head_d       = '0;
    if (count_next_c != '0) begin
      // New head is the sample being written this cycle when it lands at rd
      if (push_c && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) begin
        head_d = sample_data_c;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Overflow flag and saturating drop counter; clear wins over a drop
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  // Sample storage (contents are don't-care until pointers cover them)
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= sample_data_c;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      decim_cnt_q <= '0;
      sof_pend_q  <= 1'b1;
      vs_act_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      decim_cnt_q <= decim_cnt_d;
      sof_pend_q  <= sof_pend_d;
      vs_act_q    <= vs_act_c;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = head_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_vga_pixel_capture.sv
// Directed bench for vga_pixel_capture with default parameters
// (COLOR_W=8, DECIM=4, DEPTH=16, VS_POL=0, CNT_W=16).
module tb_vga_pixel_capture;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        visible;
  logic        hsync;
  logic        vsync;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        out_ready;
  logic        out_valid;
  logic [26:0] out_data;
  logic [4:0]  level;
  logic        overflow;
  logic        clr_ovf;
  logic [15:0] drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  vga_pixel_capture dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .visible    (visible),
    .hsync      (hsync),
    .vsync      (vsync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .level      (level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs checked 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected payload while vsync is inactive (1) and hsync is 0
  function automatic logic [26:0] pix(input logic sof, input logic [7:0] v);
    return {sof, 1'b0, 1'b1, v, v, v};
  endfunction

  task automatic set_rgb(input logic [7:0] v);
    red   = v;
    green = v;
    blue  = v;
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    visible   = 1'b0;
    hsync     = 1'b0;
    vsync     = 1'b1;
    set_rgb(8'd0);
    out_ready = 1'b0;
    clr_ovf   = 1'b0;

    // 1: reset held three cycles, then released
    tick(); tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_data", 32'(out_data), 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);

    // 2: vsync pulse then 16 visible pixels, drained every cycle
    enable    = 1'b1;
    out_ready = 1'b1;
    vsync     = 1'b0;
    tick();
    vsync     = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      visible = 1'b1;
      set_rgb(8'(i));
      tick();
      chk($sformatf("dec_valid_%0d", i), 32'(out_valid), 32'((i % 4) == 3));
      if ((i % 4) == 3) begin
        chk($sformatf("dec_data_%0d", i), 32'(out_data), 32'(pix(i == 3, 8'(i))));
      end
    end
    visible = 1'b0;
    tick();
    chk("dec_drained", 32'(level), 32'd0);

    // 3: no drain, 80 visible pixels -> 20 samples into 16 slots
    out_ready = 1'b0;
    for (int k = 0; k < 80; k++) begin
      visible = 1'b1;
      set_rgb(8'(k));
      tick();
      if (k == 63) begin
        chk("fill_level16", 32'(level), 32'd16);
        chk("fill_no_ovf", 32'(overflow), 32'd0);
      end
    end
    visible = 1'b0;
    tick();
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count), 32'd4);
    chk("ovf_valid", 32'(out_valid), 32'd1);
    chk("ovf_head", 32'(out_data), 32'(pix(1'b0, 8'd3)));

    // 4: full FIFO, push and pop on the same edge
    for (int j = 0; j < 3; j++) begin
      visible = 1'b1;
      set_rgb(8'd0);
      tick();
    end
    out_ready = 1'b1;
    set_rgb(8'd200);
    tick();
    visible = 1'b0;
    chk("pp_level", 32'(level), 32'd16);
    chk("pp_drops", 32'(drop_count), 32'd4);
    chk("pp_ovf_sticky", 32'(overflow), 32'd1);
    for (int n = 0; n < 16; n++) begin
      chk($sformatf("drain_valid_%0d", n), 32'(out_valid), 32'd1);
      chk($sformatf("drain_data_%0d", n), 32'(out_data),
          32'(pix(1'b0, (n < 15) ? 8'(7 + 4 * n) : 8'd200)));
      tick();
    end
    chk("drain_empty", 32'(level), 32'd0);
    chk("drain_valid_low", 32'(out_valid), 32'd0);

    // 5: enable dropped with decimation counter at 2, then restored
    visible = 1'b1;
    set_rgb(8'h40);
    tick();
    tick();
    chk("en_pre_none", 32'(out_valid), 32'd0);
    enable = 1'b0;
    tick();
    chk("en_off_none", 32'(out_valid), 32'd0);
    enable = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      set_rgb(8'(8'h50 + j));
      tick();
      chk($sformatf("reen_valid_%0d", j), 32'(out_valid), 32'(j == 4));
    end
    chk("reen_data", 32'(out_data), 32'(pix(1'b0, 8'h54)));
    visible = 1'b0;
    tick();
    chk("reen_drained", 32'(level), 32'd0);

    // 6: clr_ovf in the same cycle as a drop, then a fresh drop
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) begin
      visible = 1'b1;
      set_rgb(8'(k));
      tick();
    end
    chk("clr_fill_level", 32'(level), 32'd16);
    chk("clr_fill_drops", 32'(drop_count), 32'd4);
    tick(); tick(); tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    visible = 1'b0;
    chk("clr_ovf_flag", 32'(overflow), 32'd0);
    chk("clr_drops", 32'(drop_count), 32'd0);
    chk("clr_level", 32'(level), 32'd16);
    visible = 1'b1;
    tick(); tick(); tick(); tick();
    visible = 1'b0;
    chk("redrop_flag", 32'(overflow), 32'd1);
    chk("redrop_count", 32'(drop_count), 32'd1);
    chk("redrop_head", 32'(out_data), 32'(pix(1'b0, 8'd3)));

    // Asynchronous reset with a full FIFO clears everything without a clock
    #2;
    reset = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_drops", 32'(drop_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
